seg_dynamic_scan: RTL and testbench



---
 rtl/seg_dynamic_scan.sv | 146 ++++++++++++++
 tb/tb_seg_dynamic_scan.sv | 119 +++++++++++
 2 files changed

// File: rtl/seg_dynamic_scan.sv
// seg_dynamic_scan: binary-to-6-digit multiplexed 7-segment scan driver.
// Ports:
//   sys_clk  - system clock
//   sys_rst  - synchronous active-high reset
//   data     - 20-bit binary value to display
//   point    - decimal point per digit (bit n = digit n, digit 0 rightmost)
//   sign     - show a minus sign left of the shown range
//   seg_en   - display enable (scan and conversion keep running when low)
//   sel      - one-hot digit select, active-high
//   seg      - segment code, active-low, bit7 = dp, bits6..0 = g..a
// Build option: define SEG_HEX_MODE_EN to show data as 5 hex digits instead
// of decimal (the BCD converter is then left out).
module seg_dynamic_scan #(
    parameter logic [15:0] CNT_MAX = 16'd50000,
    parameter int          DIGITS  = 6
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [19:0]       data,
    input  logic [DIGITS-1:0] point,
    input  logic              sign,
    input  logic              seg_en,
    output logic [DIGITS-1:0] sel,
    output logic [7:0]        seg
);
    function automatic logic [7:0] code(input logic [3:0] v);
        case (v)
            4'h0: code = 8'hc0;
            4'h1: code = 8'hf9;
            4'h2: code = 8'ha4;
            4'h3: code = 8'hb0;
            4'h4: code = 8'h99;
            4'h5: code = 8'h92;
            4'h6: code = 8'h82;
            4'h7: code = 8'hf8;
            4'h8: code = 8'h80;
            4'h9: code = 8'h90;
            4'ha: code = 8'h88;
            4'hb: code = 8'h83;
            4'hc: code = 8'hc6;
            4'hd: code = 8'ha1;
            4'he: code = 8'h86;
            default: code = 8'h8e;
        endcase
    endfunction

    logic [4*DIGITS-1:0] res_q;
    logic                res_ovf_q;

`ifndef SEG_HEX_MODE_EN
    // Double dabble: one shift per cycle, 20 shifts after a load cycle.
    logic [4:0]          bit_q;
    logic [19:0]         sr_q;
    logic [4*DIGITS-1:0] acc_q, adj;
    logic                ovf_q;

    always_comb begin
        adj = acc_q;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bit_q     <= '0;
            sr_q      <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
        end else if (bit_q == 5'd0) begin
            sr_q  <= data;
            acc_q <= '0;
            ovf_q <= data > 20'd999999;
            bit_q <= 5'd1;
        end else begin
            acc_q <= {adj[4*DIGITS-2:0], sr_q[19]};
            sr_q  <= {sr_q[18:0], 1'b0};
            bit_q <= (bit_q == 5'd20) ? 5'd0 : bit_q + 5'd1;
            if (bit_q == 5'd20) begin
                res_q     <= {adj[4*DIGITS-2:0], sr_q[19]};
                res_ovf_q <= ovf_q;
            end
        end
    end
`else
    always_ff @(posedge sys_clk) begin
        res_q     <= sys_rst ? '0 : {4'h0, data};
        res_ovf_q <= 1'b0;
    end
`endif

    logic [15:0]         cnt_q;
    logic [2:0]          idx_q;
    logic [4*DIGITS-1:0] disp_q;
    logic                disp_ovf_q;
    logic [7:0]          seg_d;
    logic [DIGITS-1:0]   sel_d;
    logic                wrap;
    int                  top, p, hi, n;

    assign wrap  = cnt_q == CNT_MAX - 16'd1;
    assign sel_d = seg_en ? DIGITS'(1) << idx_q : '0;

    // hi is the leftmost digit of the shown range: highest nonzero digit or
    // highest decimal point, whichever is further left.
    always_comb begin
        top = 0;
        p   = -1;
        n   = int'(idx_q);
        for (int i = 0; i < DIGITS; i++) begin
            if (disp_q[4*i +: 4] != 4'h0) top = i;
            if (point[i]) p = i;
        end
        hi    = (p > top) ? p : top;
        seg_d = (n <= hi) ? code(disp_q[{idx_q, 2'b00} +: 4]) :
                (sign && n == hi + 1) ? 8'hbf : 8'hff;
`ifdef SEG_HEX_MODE_EN
        if (idx_q == 3'd5) seg_d = sign ? 8'hbf : 8'hff;
`endif
        // A set point bit always lies inside the shown range.
        seg_d[7] = seg_d[7] & ~point[idx_q];
        if (disp_ovf_q) seg_d = 8'hbf;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            disp_q     <= '0;
            disp_ovf_q <= 1'b0;
            sel        <= '0;
            seg        <= 8'hff;
        end else begin
            cnt_q <= wrap ? 16'd0 : cnt_q + 16'd1;
            // New results only enter at a digit boundary so a held digit never changes.
            if (wrap) begin
                idx_q      <= (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
                disp_q     <= res_q;
                disp_ovf_q <= res_ovf_q;
            end
            sel <= sel_d;
            seg <= seg_en ? seg_d : 8'hff;
        end
    end
endmodule

// File: tb/tb_seg_dynamic_scan.sv
// tb_seg_dynamic_scan: directed self-checking bench for seg_dynamic_scan.
module tb_seg_dynamic_scan;
    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [19:0] data;
    logic [5:0]  point;
    logic        sign;
    logic        seg_en;
    logic [5:0]  sel;
    logic [7:0]  seg;
    int          n_cmp = 0;
    int          n_bad = 0;

    seg_dynamic_scan #(.CNT_MAX(16'd10), .DIGITS(6)) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .data(data),
        .point(point),
        .sign(sign),
        .seg_en(seg_en),
        .sel(sel),
        .seg(seg)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_sel(input logic [5:0] t);
        for (int i = 0; i < 100 && sel !== t; i++) @(negedge sys_clk);
        check("sel_wait", {2'b00, sel}, {2'b00, t});
    endtask

    // exp holds {d5,d4,d3,d2,d1,d0}
    task automatic check_scan(input string tag, input logic [47:0] exp);
        for (int d = 0; d < 6; d++) begin
            wait_sel(6'(1 << d));
            check($sformatf("%s_d%0d", tag, d), seg, exp[8*d +: 8]);
        end
    endtask

    task automatic apply(input logic [19:0] d, input logic [5:0] pt, input logic sg);
        data  = d;
        point = pt;
        sign  = sg;
        repeat (70) @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    initial begin
        sys_rst = 1'b1;
        seg_en  = 1'b1;
        data    = 20'd123456;
        point   = 6'b0;
        sign    = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_sel", {2'b00, sel}, 8'h00);
        check("rst_seg", seg, 8'hff);
        sys_rst = 1'b0;

        apply(20'd123456, 6'b000000, 1'b0);
        check_scan("n123456", 48'hf9_a4_b0_99_92_82);
        apply(20'd5, 6'b000010, 1'b1);
        check_scan("n5_dp_sign", 48'hff_ff_ff_bf_40_92);
        apply(20'd0, 6'b000000, 1'b0);
        check_scan("zero", 48'hff_ff_ff_ff_ff_c0);
        apply(20'd1000000, 6'b111111, 1'b1);
        check_scan("ovf", 48'hbf_bf_bf_bf_bf_bf);
        apply(20'd999999, 6'b000000, 1'b1);
        check_scan("max_sign_drop", 48'h90_90_90_90_90_90);

        apply(20'd123456, 6'b000000, 1'b0);
        wait_sel(6'b100000);
        wait_sel(6'b000001);
        seg_en = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check("dis_sel", {2'b00, sel}, 8'h00);
        check("dis_seg", seg, 8'hff);
        repeat (23) @(posedge sys_clk);
        @(negedge sys_clk);
        seg_en = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check("reen_sel", {2'b00, sel}, 8'h04);
        check("reen_seg", seg, 8'h99);

        wait_sel(6'b001000);
        repeat (4) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check("mid_rst_sel", {2'b00, sel}, 8'h00);
        check("mid_rst_seg", seg, 8'hff);
        sys_rst = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        check("post_rst_sel0", {2'b00, sel}, 8'h01);
        check("post_rst_seg0", seg, 8'hc0);
        repeat (9) @(posedge sys_clk);
        @(negedge sys_clk);
        check("hold_sel0", {2'b00, sel}, 8'h01);
        @(posedge sys_clk);
        @(negedge sys_clk);
        check("adv_sel1", {2'b00, sel}, 8'h02);
        check("adv_seg1", seg, 8'hff);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
